// File: rtl/lcd_mode_sequencer.sv
// rtl/lcd_mode_sequencer.sv - HD44780 init plus mode banner writer for the mode-switching app
// Owns the LCD bus; every write is a SETUP cycle followed by a one-cycle STROBE.
module lcd_mode_sequencer #(
    parameter int PWR_DLY  = 3,
    parameter int CLR_WAIT = 1
) (
    input  logic       clk_100hz,
    input  logic       rst,
    input  logic [1:0] mode_sel,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data,
    output logic       busy
);

    localparam int CNT_MAX = (PWR_DLY > CLR_WAIT) ? PWR_DLY : CLR_WAIT;
    localparam int CW      = $clog2(CNT_MAX + 2);

    localparam logic [127:0] L1_WATCH = {"WATCH", {11{8'h20}}};
    localparam logic [127:0] L1_STOPW = {"STOPWATCH", {7{8'h20}}};
    localparam logic [127:0] L1_ALARM = {"ALARM SET", {7{8'h20}}};
    localparam logic [127:0] L1_INVAL = {"----", {12{8'h20}}};
    localparam logic [39:0]  L2_HEAD  = "MODE ";

    typedef enum logic [2:0] {
        S_PWR_WAIT,
        S_INIT,
        S_CLR_WAIT,
        S_REFRESH,
        S_IDLE
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [5:0]     idx, idx_n;
    logic [1:0]     cur_mode, cur_mode_n;
    logic [1:0]     sync1, sync2;
    logic           e_n, rs_n, busy_n;
    logic [7:0]     data_n;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    endfunction

    // Write 0 = line-1 address, 1..16 line 1, 17 = line-2 address, 18..33 line 2.
    function automatic logic [7:0] refresh_byte(input logic [5:0] i, input logic [1:0] m);
        logic [127:0] line;
        logic [3:0]   pos;
        line = '0;
        pos  = '0;
        refresh_byte = 8'h80;
        if (i == 6'd17) begin
            refresh_byte = 8'hC0;
        end else if (i != 6'd0) begin
            if (i <= 6'd16) begin
                pos = 4'(i - 6'd1);
                case (m)
                    2'd0:    line = L1_WATCH;
                    2'd1:    line = L1_STOPW;
                    2'd2:    line = L1_ALARM;
                    default: line = L1_INVAL;
                endcase
            end else begin
                pos  = 4'(i - 6'd18);
                line = {L2_HEAD, 8'h30 + {6'd0, m}, {10{8'h20}}};
            end
            line = line << {pos, 3'b000};
            refresh_byte = line[127:120];
        end
    endfunction

    assign lcd_rw = 1'b0;

    always_ff @(posedge clk_100hz or posedge rst) begin
        if (rst) begin
            state    <= S_PWR_WAIT;
            cnt      <= '0;
            idx      <= '0;
            cur_mode <= '0;
            sync1    <= '0;
            sync2    <= '0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
            busy     <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            cur_mode <= cur_mode_n;
            sync1    <= mode_sel;
            sync2    <= sync1;
            lcd_e    <= e_n;
            lcd_rs   <= rs_n;
            lcd_data <= data_n;
            busy     <= busy_n;
        end
    end

    // lcd_e doubles as the slot phase: 0 = SETUP just issued, 1 = STROBE just issued.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        idx_n      = idx;
        cur_mode_n = cur_mode;
        e_n        = 1'b0;
        rs_n       = lcd_rs;
        data_n     = lcd_data;
        case (state)
            S_PWR_WAIT: begin
                if (cnt == CW'(PWR_DLY)) begin
                    state_n = S_INIT;
                    idx_n   = '0;
                    rs_n    = 1'b0;
                    data_n  = init_cmd(2'd0);
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_INIT: begin
                if (!lcd_e) begin
                    e_n = 1'b1;
                end else if (idx == 6'd3) begin
                    state_n = S_CLR_WAIT;
                    cnt_n   = CW'(1);
                end else begin
                    idx_n  = idx + 6'd1;
                    data_n = init_cmd(idx_n[1:0]);
                end
            end
            S_CLR_WAIT: begin
                if (cnt >= CW'(CLR_WAIT)) begin
                    state_n    = S_REFRESH;
                    idx_n      = '0;
                    cur_mode_n = sync2;
                    rs_n       = 1'b0;
                    data_n     = 8'h80;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_REFRESH: begin
                if (!lcd_e) begin
                    e_n = 1'b1;
                end else if (idx == 6'd33) begin
                    state_n = S_IDLE;
                end else begin
                    idx_n  = idx + 6'd1;
                    rs_n   = (idx_n != 6'd17);
                    data_n = refresh_byte(idx_n, cur_mode);
                end
            end
            S_IDLE: begin
                if (sync2 != cur_mode) begin
                    state_n    = S_REFRESH;
                    idx_n      = '0;
                    cur_mode_n = sync2;
                    rs_n       = 1'b0;
                    data_n     = 8'h80;
                end
            end
            default: state_n = S_PWR_WAIT;
        endcase
        busy_n = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_lcd_mode_sequencer.sv
// tb/tb_lcd_mode_sequencer.sv - self-checking bench for lcd_mode_sequencer
// Strobed writes are logged and compared with banners built from the mode names.
module tb_lcd_mode_sequencer;

    logic       clk_100hz = 1'b0;
    logic       rst;
    logic [1:0] mode_sel;
    logic       lcd_e, lcd_rs, lcd_rw, busy;
    logic [7:0] lcd_data;

    int vectors     = 0;
    int miscompares = 0;
    int disp        = 0;

    logic [8:0] wlog[$];
    logic [8:0] exp_q[$];
    logic       prev_e    = 1'b0;
    logic       prev_rs   = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] init_cmds [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

    lcd_mode_sequencer #(.PWR_DLY(3), .CLR_WAIT(1)) dut (
        .clk_100hz (clk_100hz),
        .rst       (rst),
        .mode_sel  (mode_sel),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_data  (lcd_data),
        .busy      (busy)
    );

    always #5 clk_100hz = ~clk_100hz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_100hz);
        #1;
    endtask

    task automatic add_init();
        foreach (init_cmds[i]) exp_q.push_back({1'b0, init_cmds[i]});
    endtask

    task automatic add_refresh(input int m);
        string l1, l2;
        case (m)
            0:       l1 = "WATCH";
            1:       l1 = "STOPWATCH";
            2:       l1 = "ALARM SET";
            default: l1 = "----";
        endcase
        l2 = $sformatf("MODE %0d", m);
        exp_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, (i < l1.len()) ? l1[i] : 8'h20});
        exp_q.push_back({1'b0, 8'hC0});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, (i < l2.len()) ? l2[i] : 8'h20});
    endtask

    task automatic check_log(input string tag);
        int first_bad;
        first_bad = -1;
        for (int i = 0; i < wlog.size() && i < exp_q.size(); i++)
            if (wlog[i] !== exp_q[i] && first_bad < 0) first_bad = i;
        vectors++;
        assert (wlog.size() == exp_q.size() && first_bad < 0) else begin
            miscompares++;
            $error("FAIL %s: observed %0d writes (first diff at %0d) expected %0d writes",
                   tag, wlog.size(), first_bad, exp_q.size());
        end
        wlog.delete();
        exp_q.delete();
    endtask

    task automatic change_mode(input int m);
        int cnt;
        mode_sel = 2'(m);
        step();
        chk("idle_t0_busy", busy, 0);
        step();
        chk("idle_t1_busy", busy, 0);
        step();
        chk("chg_busy", busy, 1);
        chk("chg_setup", {lcd_e, lcd_rs, lcd_data}, {2'b00, 8'h80});
        cnt = 0;
        while (busy === 1'b1 && cnt < 300) begin
            step();
            cnt++;
        end
        chk("refresh_cycles", cnt, 68);
        add_refresh(m);
        check_log("refresh_text");
        disp = m;
    endtask

    task automatic busy_run(input int a, input int b, input int d);
        mode_sel = 2'(a);
        repeat (3) step();
        chk("run_busy", busy, 1);
        repeat (8) step();
        mode_sel = 2'(b);
        repeat (6) step();
        mode_sel = 2'(d);
        repeat (210) step();
        chk("run_idle", busy, 0);
        add_refresh(a);
        if (d != a) add_refresh(d);
        check_log("run_log");
        disp = d;
    endtask

    task automatic powerup_seq(input int m);
        for (int n = 1; n <= 81; n++) begin
            step();
            if (n <= 3) begin
                chk("pwr_wait_bus", {lcd_e, lcd_rs, lcd_data}, 10'h000);
                chk("pwr_wait_busy", busy, 1);
            end else if (n <= 11) begin
                chk("init_bus", {lcd_e, lcd_rs, lcd_data},
                    {((n - 4) % 2 == 1) ? 1'b1 : 1'b0, 1'b0, init_cmds[(n - 4) / 2]});
            end else if (n == 12) begin
                chk("clr_wait_bus", {lcd_e, lcd_data}, {1'b0, 8'h01});
            end else if (n == 13) begin
                chk("ref_first_setup", {lcd_e, lcd_rs, lcd_data}, {2'b00, 8'h80});
            end else if (n == 16 && m == 0) begin
                chk("ref_w_strobe", {lcd_e, lcd_rs, lcd_data}, {2'b11, 8'h57});
            end else if (n == 48) begin
                chk("ref_c0_strobe", {lcd_e, lcd_rs, lcd_data}, {2'b10, 8'hC0});
            end else if (n == 60) begin
                chk("ref_digit_strobe", {lcd_e, lcd_rs, lcd_data}, {2'b11, 8'h30 + 8'(m)});
            end else if (n == 80) begin
                chk("busy_at_80", busy, 1);
            end else if (n == 81) begin
                chk("idle_at_81", {busy, lcd_e}, 2'b00);
            end
        end
        add_init();
        add_refresh(m);
        check_log("powerup_log");
        disp = m;
    endtask

    always @(negedge clk_100hz) begin
        if (rst !== 1'b0) begin
            prev_e    = 1'b0;
            prev_rs   = 1'b0;
            prev_data = 8'h00;
        end else begin
            chk("rw_zero", lcd_rw, 0);
            if (lcd_e === 1'b1) begin
                chk("strobe_after_setup", {prev_e, prev_rs, prev_data}, {1'b0, lcd_rs, lcd_data});
                wlog.push_back({lcd_rs, lcd_data});
            end
            prev_e    = lcd_e;
            prev_rs   = lcd_rs;
            prev_data = lcd_data;
        end
    end

    initial begin
        int m, a, b, d;
        rst      = 1'b1;
        mode_sel = 2'd0;
        repeat (2) @(posedge clk_100hz);
        #2 rst = 1'b0;
        wlog.delete();

        // Reset asserted mid-strobe must clear the bus before any edge.
        repeat (5) step();
        chk("pre_rst_strobe", {lcd_e, lcd_data}, {1'b1, 8'h38});
        #1 rst = 1'b1;
        #1;
        chk("rst_bus", {lcd_e, lcd_rs, lcd_rw, lcd_data}, {3'b000, 8'h00});
        chk("rst_busy", busy, 1);
        repeat (2) @(posedge clk_100hz);
        #2 rst = 1'b0;
        wlog.delete();

        powerup_seq(0);

        change_mode(1);
        change_mode(3);
        for (int k = 0; k < 6; k++) begin
            m = (disp + int'($urandom_range(1, 3))) % 4;
            change_mode(m);
            repeat ($urandom_range(0, 5)) step();
        end

        if (disp == 1) change_mode(0);
        busy_run(1, 2, 0);
        busy_run(1, 2, 1);
        for (int k = 0; k < 3; k++) begin
            a = (disp + int'($urandom_range(1, 3))) % 4;
            b = int'($urandom_range(0, 3));
            d = int'($urandom_range(0, 3));
            busy_run(a, b, d);
        end

        // Reset at the STROBE edge of the 10th refresh write, then full restart.
        m = (disp + 1) % 4;
        mode_sel = 2'(m);
        repeat (3) step();
        chk("pre_rst_setup", {lcd_e, lcd_data}, {1'b0, 8'h80});
        repeat (19) step();
        chk("tenth_strobe", {lcd_e, lcd_rs}, 2'b11);
        #1 rst = 1'b1;
        #1;
        chk("midwrite_rst_bus", {lcd_e, lcd_rs, lcd_data}, 10'h000);
        chk("midwrite_rst_busy", busy, 1);
        repeat (2) @(posedge clk_100hz);
        #2 rst = 1'b0;
        wlog.delete();
        powerup_seq(m);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
